mysystem_done_pio_in: RTL and testbench



---
 rtl/mysystem_pio_pkg.sv | 22 ++
 rtl/mysystem_pio_sync_edge.sv | 65 ++++++
 rtl/mysystem_done_pio_in.sv | 94 +++++++++
 tb/tb_mysystem_done_pio_in.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mysystem_pio_pkg.sv
// Shared definitions for the mysystem PIO slaves: register word addresses
// and the edge-capture mode encodings used by the input PIO.
package mysystem_pio_pkg;

    // Word addresses of the PIO register map
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Edge-capture modes
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Number of cycles edge detection stays suppressed after reset: the
    // chain needs SYNC_STAGES cycles to refill and prev_q one more.
    function automatic int arm_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/mysystem_pio_sync_edge.sv
// Input synchroniser and edge detector for the input PIO.
// Each bit passes through a SYNC_STAGES-deep flop chain; sync_q is the last
// stage. Edges are qualified by an arming counter so an input that is already
// high when reset releases does not look like a fresh edge.
module mysystem_pio_sync_edge
    import mysystem_pio_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_det
);

    localparam int ARM_CYCLES = arm_cycles(SYNC_STAGES);
    localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]                  prev_q;
    logic [CNT_W-1:0]                  arm_cnt;
    logic                              armed;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;
    logic [WIDTH-1:0]                  raw_edge;

    assign sync_q = sync_r[SYNC_STAGES-1];
    assign armed  = (arm_cnt == CNT_W'(ARM_CYCLES));
    assign rise   = sync_q & ~prev_q;
    assign fall   = ~sync_q & prev_q;

    // Synchroniser shift: stage 0 samples the pin, the top stage is sync_q
    always_ff @(posedge clk) begin
        if (reset) sync_r <= '0;
        else       sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
    end

    // Previous synchronised value for edge comparison
    always_ff @(posedge clk) begin
        if (reset) prev_q <= '0;
        else       prev_q <= sync_q;
    end

    // Arming counter: counts up after reset and saturates once armed
    always_ff @(posedge clk) begin
        if (reset)       arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign raw_edge = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign raw_edge = rise | fall;
        end else begin : g_rise
            assign raw_edge = rise;
        end
    endgenerate

    assign edge_det = raw_edge & {WIDTH{armed}};

endmodule

// File: rtl/mysystem_done_pio_in.sv
// Avalon-MM input PIO returning fabric status (e.g. accelerator "done") to
// the host. Holds the register file, edge-capture clear logic and the level
// interrupt; synchronisation and edge detection live in mysystem_pio_sync_edge.
// Optional build macro MYSYSTEM_PIO_IN_BITCLR_EN: when defined, writes to
// EDGECAP are write-1-to-clear per bit; otherwise any write clears all bits.
module mysystem_done_pio_in
    import mysystem_pio_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] ecap_clr;

    assign wr_en = chipselect & ~write_n;

    mysystem_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync_q   (sync_q),
        .edge_det (edge_det)
    );

    // Bits of EDGECAP cleared by this cycle's bus write
    always_comb begin
        ecap_clr = '0;
        if (wr_en && address == PIO_ADDR_EDGECAP) begin
`ifdef MYSYSTEM_PIO_IN_BITCLR_EN
            ecap_clr = writedata[WIDTH-1:0];
`else
            ecap_clr = '1;
`endif
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset)                                     irqmask <= '0;
        else if (wr_en && address == PIO_ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end

    // Sticky edge capture; the OR after the clear makes a same-cycle set win
    always_ff @(posedge clk) begin
        if (reset) edgecap <= '0;
        else       edgecap <= (edgecap & ~ecap_clr) | edge_det;
    end

    // Registered level interrupt from masked capture bits
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(edgecap & irqmask);
    end

    // Zero-wait-state read mux, driven independent of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = sync_q;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:          readdata = '0;
        endcase
    end

    // Write data above WIDTH has no destination
    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd_hi;
            assign unused_wd_hi = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_mysystem_done_pio_in.sv
// Self-checking bench for mysystem_done_pio_in (WIDTH=4, rising edge,
// 2 sync stages). Expected values go into a scoreboard queue as each
// stimulus/read is issued and are popped against the DUT's output.
module tb_mysystem_done_pio_in;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    mysystem_done_pio_in #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            chk("sb_empty", obs, 32'hDEAD_BEEF);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd_exp(input string tag, input logic [1:0] a, input logic [31:0] e);
        address = a;
        sb_push(tag, e);
        #1;
        sb_pop(readdata);
    endtask

    task automatic irq_exp(input string tag, input logic e);
        sb_push(tag, {31'b0, e});
        sb_pop({31'b0, irq});
    endtask

    logic [31:0] bitclr_exp;

    initial begin
`ifdef MYSYSTEM_PIO_IN_BITCLR_EN
        bitclr_exp = 32'hA;
`else
        bitclr_exp = 32'h0;
`endif
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Reset with inputs held high
        tick(3);
        rd_exp("rst_data", 2'd0, 32'h0);
        rd_exp("rst_mask", 2'd2, 32'h0);
        rd_exp("rst_ecap", 2'd3, 32'h0);
        irq_exp("rst_irq", 1'b0);
        reset = 1'b0;
        tick(1);
        rd_exp("data_lat1", 2'd0, 32'h0);
        tick(1);
        rd_exp("data_lat2", 2'd0, 32'hF);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            rd_exp("arm_ecap", 2'd3, 32'h0);
            irq_exp("arm_irq", 1'b0);
        end

        // Single pulse on bit 0 with mask enabled, then clear
        in_port = 4'h0;
        tick(4);
        wr(2'd2, 32'h1);
        rd_exp("mask_rb", 2'd2, 32'h1);
        rd_exp("fall_ignored", 2'd3, 32'h0);
        in_port = 4'h1;
        tick(1);
        in_port = 4'h0;
        tick(1);
        rd_exp("pulse_ecap_early", 2'd3, 32'h0);
        tick(1);
        rd_exp("pulse_ecap", 2'd3, 32'h1);
        irq_exp("pulse_irq_lag", 1'b0);
        tick(1);
        irq_exp("pulse_irq", 1'b1);
        wr(2'd3, 32'h1);
        rd_exp("clr_ecap", 2'd3, 32'h0);
        irq_exp("clr_irq_lag", 1'b1);
        tick(1);
        irq_exp("clr_irq", 1'b0);

        // Masked capture, then unmask
        wr(2'd2, 32'h0);
        in_port = 4'h1;
        tick(1);
        in_port = 4'h0;
        tick(3);
        rd_exp("masked_ecap", 2'd3, 32'h1);
        irq_exp("masked_irq", 1'b0);
        tick(2);
        irq_exp("masked_irq_hold", 1'b0);
        wr(2'd2, 32'h1);
        irq_exp("unmask_irq_lag", 1'b0);
        tick(1);
        irq_exp("unmask_irq", 1'b1);

        // Reserved address and writes to read-only DATA
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF);
        rd_exp("rsvd_rd", 2'd1, 32'h0);
        rd_exp("data_ro", 2'd0, 32'h0);
        tick(1);
        rd_exp("rsvd_mask", 2'd2, 32'h1);
        rd_exp("rsvd_ecap", 2'd3, 32'h1);
        irq_exp("rsvd_irq", 1'b1);

        // Clear modes on EDGECAP = 4'b1011
        in_port = 4'hA;
        tick(1);
        in_port = 4'h0;
        tick(3);
        rd_exp("ecap_1011", 2'd3, 32'hB);
        wr(2'd3, 32'h1);
        rd_exp("bitclr", 2'd3, bitclr_exp);
        wr(2'd3, 32'hF);
        rd_exp("clr_all", 2'd3, 32'h0);
        tick(1);
        irq_exp("clr_all_irq", 1'b0);

        // Clear colliding with a new rising edge on bit 0: set wins
        in_port = 4'h1;
        tick(1);
        in_port = 4'h0;
        tick(4);
        rd_exp("pre_ecap", 2'd3, 32'h1);
        irq_exp("pre_irq", 1'b1);
        in_port = 4'h1;
        tick(1);
        in_port = 4'h0;
        tick(1);
        wr(2'd3, 32'hF);
        rd_exp("setwins_ecap", 2'd3, 32'h1);
        irq_exp("setwins_irq", 1'b1);
        tick(1);
        irq_exp("setwins_irq2", 1'b1);

        // Reset mid-operation with inputs high
        in_port = 4'hF;
        tick(3);
        rd_exp("pre_rst_data", 2'd0, 32'hF);
        reset = 1'b1;
        tick(1);
        rd_exp("mid_rst_data", 2'd0, 32'h0);
        rd_exp("mid_rst_mask", 2'd2, 32'h0);
        rd_exp("mid_rst_ecap", 2'd3, 32'h0);
        irq_exp("mid_rst_irq", 1'b0);
        reset = 1'b0;
        tick(10);
        rd_exp("post_rst_ecap", 2'd3, 32'h0);
        rd_exp("post_rst_data", 2'd0, 32'hF);
        irq_exp("post_rst_irq", 1'b0);

        if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
